// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the instruction/data request arbiter: requester IDs,
// grant FSM states, the downstream command bundle and the default depth.
package mem_req_arbiter_pkg;

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } grant_st_e;

    localparam int OUTSTANDING_DEF = 4;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_cmd_t;

    function automatic grant_st_e lock_state(input req_id_e id);
        return (id == REQ_DATA) ? ST_LOCK_D : ST_LOCK_I;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of both requester ports, the shared downstream port and the cancel pulse.
// slave is the arbiter's view; master is the view of whoever drives the requesters/memory.
interface mem_req_arbiter_if;

    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    logic        inst_cancel;

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
               inst_sram_wstrb, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_cancel
    );

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
               inst_sram_wstrb, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_cancel
    );

endinterface

// File: rtl/req_track_fifo.sv
// In-order tracker of accepted requests: one requester ID and one discard flag
// per entry, so returning responses can be steered (or dropped) in issue order.
module req_track_fifo
    import mem_req_arbiter_pkg::*;
#(
    parameter int DEPTH = OUTSTANDING_DEF
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_push,
    input  req_id_e i_push_id,
    input  logic    i_push_discard,
    input  logic    i_pop,
    input  logic    i_flag_inst_discard,
    output req_id_e o_head_id,
    output logic    o_head_discard,
    output logic    o_full,
    output logic    o_empty
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    req_id_e          r_id [DEPTH];
    logic [DEPTH-1:0] r_disc;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full         = (r_cnt == FULL_CNT);
    assign o_empty        = (r_cnt == '0);
    // A push into a full FIFO is fine as long as the head leaves in the same cycle.
    assign w_push         = i_push && (!o_full || i_pop);
    assign w_pop          = i_pop && !o_empty;
    assign o_head_id      = r_id[r_rptr];
    assign o_head_discard = r_disc[r_rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Stale slots may pick up a discard mark; the push below always rewrites it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disc <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_flag_inst_discard && (r_id[i] == REQ_INST)) r_disc[i] <= 1'b1;
            end
            if (w_push) r_disc[r_wptr] <= i_push_discard;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_id[r_wptr] <= i_push_id;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the instruction and data SRAM-like requesters onto one memory port.
// Fixed data-first priority by default; define ARB_RR_EN for round-robin.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = OUTSTANDING_DEF
) (
    input  logic                clk,
    input  logic                reset,
    mem_req_arbiter_if.slave    bus
);

    grant_st_e r_state;
    req_id_e   w_gid;
    req_id_e   w_head_id;
    logic      w_mem_req;
    logic      w_accept;
    logic      w_pop;
    logic      w_full;
    logic      w_empty;
    logic      w_head_disc;
    mem_cmd_t  w_inst_cmd;
    mem_cmd_t  w_data_cmd;
    mem_cmd_t  w_cmd;
`ifdef ARB_RR_EN
    req_id_e   r_last;
`endif

    assign w_inst_cmd = '{wr: bus.inst_sram_wr, size: bus.inst_sram_size,
                          addr: bus.inst_sram_addr, wstrb: bus.inst_sram_wstrb,
                          wdata: bus.inst_sram_wdata};
    assign w_data_cmd = '{wr: bus.data_sram_wr, size: bus.data_sram_size,
                          addr: bus.data_sram_addr, wstrb: bus.data_sram_wstrb,
                          wdata: bus.data_sram_wdata};

    always_comb begin
        w_gid     = REQ_INST;
        w_mem_req = 1'b0;
        case (r_state)
            ST_LOCK_I: begin
                w_gid     = REQ_INST;
                w_mem_req = bus.inst_sram_req;
            end
            ST_LOCK_D: begin
                w_gid     = REQ_DATA;
                w_mem_req = bus.data_sram_req;
            end
            default: begin
`ifdef ARB_RR_EN
                if (bus.inst_sram_req && bus.data_sram_req)
                    w_gid = (r_last == REQ_INST) ? REQ_DATA : REQ_INST;
                else
                    w_gid = bus.data_sram_req ? REQ_DATA : REQ_INST;
`else
                w_gid = bus.data_sram_req ? REQ_DATA : REQ_INST;
`endif
                w_mem_req = !w_full && (bus.inst_sram_req || bus.data_sram_req);
            end
        endcase
        // No handshake is offered while reset is held.
        if (reset) w_mem_req = 1'b0;
    end

    assign w_cmd    = (w_gid == REQ_DATA) ? w_data_cmd : w_inst_cmd;
    assign w_accept = w_mem_req && bus.mem_addr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_mem_req && !bus.mem_addr_ok) r_state <= lock_state(w_gid);
                ST_LOCK_I,
                ST_LOCK_D: if (w_accept) r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset)         r_last <= REQ_INST;
        else if (w_accept) r_last <= w_gid;
    end
`endif

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_wr    = w_cmd.wr;
    assign bus.mem_size  = w_cmd.size;
    assign bus.mem_addr  = w_cmd.addr;
    assign bus.mem_wstrb = w_cmd.wstrb;
    assign bus.mem_wdata = w_cmd.wdata;

    assign bus.inst_sram_addr_ok = w_accept && (w_gid == REQ_INST);
    assign bus.data_sram_addr_ok = w_accept && (w_gid == REQ_DATA);

    // A response with nothing outstanding is dropped without touching the tracker.
    assign w_pop = bus.mem_data_ok && !w_empty && !reset;

    // A cancel in the pop cycle must also suppress the head's response.
    assign bus.inst_sram_data_ok = w_pop && (w_head_id == REQ_INST) && !w_head_disc &&
                                   !bus.inst_cancel;
    assign bus.data_sram_data_ok = w_pop && (w_head_id == REQ_DATA);
    assign bus.inst_sram_rdata   = bus.mem_rdata;
    assign bus.data_sram_rdata   = bus.mem_rdata;

    req_track_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_track (
        .clk                 (clk),
        .reset               (reset),
        .i_push              (w_accept),
        .i_push_id           (w_gid),
        .i_push_discard      (bus.inst_cancel && (w_gid == REQ_INST)),
        .i_pop               (w_pop),
        .i_flag_inst_discard (bus.inst_cancel),
        .o_head_id           (w_head_id),
        .o_head_discard      (w_head_disc),
        .o_full              (w_full),
        .o_empty             (w_empty)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the grant, tracking and cancel rules.
module tb_mem_req_arbiter;

    localparam int OUT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_req_arbiter_if bus();

    mem_req_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        bit id;
        bit disc;
    } ent_t;

    ent_t q[$];
    int   lockv = -1;
    bit   last  = 1'b0;
    bit   e_iaok;
    bit   e_daok;
    bit   ipend;
    bit   dpend;

    // Evaluate the model against the current inputs, check outputs, then advance one clock.
    task automatic tick();
        bit   ir, dr, full, mreq, acc, pop, gid;
        ent_t hd, tmp;
        #2;
        ir = bus.inst_sram_req;
        dr = bus.data_sram_req;
        gid = 1'b0;
        if (reset) begin
            mreq = 1'b0;
        end else if (lockv >= 0) begin
            gid  = lockv[0];
            mreq = gid ? dr : ir;
        end else begin
            full = (q.size() == OUT);
`ifdef ARB_RR_EN
            gid = (ir && dr) ? ~last : dr;
`else
            gid = dr;
`endif
            mreq = !full && (ir || dr);
        end
        acc = mreq && bus.mem_addr_ok;
        pop = !reset && bus.mem_data_ok && (q.size() > 0);
        hd  = pop ? q[0] : '0;

        chk("mem_req", 32'(bus.mem_req), 32'(mreq));
        if (mreq) begin
            chk("mem_addr",  bus.mem_addr,  gid ? bus.data_sram_addr : bus.inst_sram_addr);
            chk("mem_wdata", bus.mem_wdata, gid ? bus.data_sram_wdata : bus.inst_sram_wdata);
            chk("mem_wr",    32'(bus.mem_wr), 32'(gid ? bus.data_sram_wr : bus.inst_sram_wr));
            chk("mem_size",  32'(bus.mem_size),
                32'(gid ? bus.data_sram_size : bus.inst_sram_size));
            chk("mem_wstrb", 32'(bus.mem_wstrb),
                32'(gid ? bus.data_sram_wstrb : bus.inst_sram_wstrb));
        end
        chk("inst_addr_ok", 32'(bus.inst_sram_addr_ok), 32'(acc && !gid));
        chk("data_addr_ok", 32'(bus.data_sram_addr_ok), 32'(acc && gid));
        chk("inst_data_ok", 32'(bus.inst_sram_data_ok),
            32'(pop && !hd.id && !hd.disc && !bus.inst_cancel));
        chk("data_data_ok", 32'(bus.data_sram_data_ok), 32'(pop && hd.id));
        chk("inst_rdata", bus.inst_sram_rdata, bus.mem_rdata);
        chk("data_rdata", bus.data_sram_rdata, bus.mem_rdata);
        e_iaok = acc && !gid;
        e_daok = acc && gid;

        if (reset) begin
            q.delete();
            lockv = -1;
            last  = 1'b0;
        end else begin
            if (bus.inst_cancel) begin
                foreach (q[i]) begin
                    if (!q[i].id) begin
                        tmp = q[i];
                        tmp.disc = 1'b1;
                        q[i] = tmp;
                    end
                end
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(ent_t'{id: gid, disc: bus.inst_cancel && !gid});
            if (lockv < 0 && mreq && !bus.mem_addr_ok) lockv = int'(gid);
            else if (lockv >= 0 && acc)                lockv = -1;
            if (acc) last = gid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic inst_req(input logic on, input logic [31:0] a);
        bus.inst_sram_req   = on;
        bus.inst_sram_addr  = a;
        bus.inst_sram_wr    = 1'b0;
        bus.inst_sram_size  = 2'd2;
        bus.inst_sram_wstrb = 4'h0;
        bus.inst_sram_wdata = 32'h0;
    endtask

    task automatic data_req(input logic on, input logic wr, input logic [31:0] a);
        bus.data_sram_req   = on;
        bus.data_sram_addr  = a;
        bus.data_sram_wr    = wr;
        bus.data_sram_size  = 2'd2;
        bus.data_sram_wstrb = wr ? 4'hF : 4'h0;
        bus.data_sram_wdata = a ^ 32'h5A5A_0000;
    endtask

    task automatic mem_drv(input logic aok, input logic dok, input logic [31:0] rd);
        bus.mem_addr_ok = aok;
        bus.mem_data_ok = dok;
        bus.mem_rdata   = rd;
    endtask

    task automatic drain();
        inst_req(1'b0, 32'h0);
        data_req(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < OUT + 2; i++) begin
            mem_drv(1'b0, 1'b1, 32'h1000 + i);
            tick();
        end
        mem_drv(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        inst_req(1'b0, 32'h0);
        data_req(1'b0, 1'b0, 32'h0);
        mem_drv(1'b0, 1'b0, 32'h0);
        bus.inst_cancel = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b0;
        #2;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_data_ok", 32'(bus.data_sram_data_ok), 32'd0);
        tick();

        // Single read
        data_req(1'b1, 1'b0, 32'h1000);
        mem_drv(1'b1, 1'b0, 32'h0);
        #2;
        chk("rd_daok", 32'(bus.data_sram_addr_ok), 32'd1);
        chk("rd_addr", bus.mem_addr, 32'h1000);
        tick();
        data_req(1'b0, 1'b0, 32'h0);
        mem_drv(1'b0, 1'b0, 32'h0);
        tick();
        mem_drv(1'b0, 1'b1, 32'hDEAD_BEEF);
        #2;
        chk("rd_dok", 32'(bus.data_sram_data_ok), 32'd1);
        chk("rd_rdata", bus.data_sram_rdata, 32'hDEAD_BEEF);
        tick();
        mem_drv(1'b0, 1'b0, 32'h0);
        tick();

        // Simultaneous requests
        inst_req(1'b1, 32'h1c00_0000);
        data_req(1'b1, 1'b0, 32'h2000);
        mem_drv(1'b1, 1'b0, 32'h0);
`ifndef ARB_RR_EN
        #2;
        chk("pri_first", bus.mem_addr, 32'h2000);
`endif
        tick();
        if (e_daok) data_req(1'b0, 1'b0, 32'h0);
        if (e_iaok) inst_req(1'b0, 32'h0);
`ifndef ARB_RR_EN
        #2;
        chk("pri_second", bus.mem_addr, 32'h1c00_0000);
`endif
        tick();
        drain();

        // Round-robin alternation over four pairs (fixed priority: data always first)
        for (int p = 0; p < 4; p++) begin
            inst_req(1'b1, 32'h1c00_0100 + 32'(p));
            data_req(1'b1, 1'b1, 32'h3000 + 32'(p));
            mem_drv(1'b1, 1'b1, 32'h0);
            tick();
            if (e_daok) data_req(1'b0, 1'b0, 32'h0);
            if (e_iaok) inst_req(1'b0, 32'h0);
            tick();
        end
        drain();

        // Lock holds inst grant while data arrives
        inst_req(1'b1, 32'h1c00_0000);
        mem_drv(1'b0, 1'b0, 32'h0);
        tick();
        data_req(1'b1, 1'b0, 32'h2000);
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("lock_addr", bus.mem_addr, 32'h1c00_0000);
            tick();
        end
        mem_drv(1'b1, 1'b0, 32'h0);
        #2;
        chk("lock_iaok", 32'(bus.inst_sram_addr_ok), 32'd1);
        chk("lock_daok", 32'(bus.data_sram_addr_ok), 32'd0);
        tick();
        inst_req(1'b0, 32'h0);
        #2;
        chk("lock_next", bus.mem_addr, 32'h2000);
        tick();
        drain();

        // Full tracker
        mem_drv(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < OUT; k++) begin
            inst_req(1'b1, 32'h1c00_0200 + 32'(k));
            tick();
        end
        #2;
        chk("full_noreq", 32'(bus.mem_req), 32'd0);
        mem_drv(1'b1, 1'b1, 32'h1111_0000);
        tick();
        #2;
        chk("full_reopen", 32'(bus.mem_req), 32'd1);
        tick();
        mem_drv(1'b1, 1'b0, 32'h0);
        tick();
        #2;
        chk("full_again", 32'(bus.mem_req), 32'd0);
        tick();
        drain();

        // Cancel
        mem_drv(1'b1, 1'b0, 32'h0);
        inst_req(1'b1, 32'h1c00_0300);
        tick();
        inst_req(1'b1, 32'h1c00_0304);
        tick();
        inst_req(1'b0, 32'h0);
        bus.inst_cancel = 1'b1;
        tick();
        bus.inst_cancel = 1'b0;
        data_req(1'b1, 1'b0, 32'h4000);
        tick();
        data_req(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            mem_drv(1'b0, 1'b1, 32'hCAFE_0000 + 32'(k));
            #2;
            chk("cancel_idok", 32'(bus.inst_sram_data_ok), 32'd0);
            tick();
        end
        mem_drv(1'b0, 1'b1, 32'h0BAD_F00D);
        #2;
        chk("cancel_ddok", 32'(bus.data_sram_data_ok), 32'd1);
        tick();
        mem_drv(1'b0, 1'b0, 32'h0);
        tick();

        // Reset with entries outstanding
        mem_drv(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            data_req(1'b1, 1'b0, 32'h5000 + 32'(k));
            tick();
        end
        data_req(1'b0, 1'b0, 32'h0);
        mem_drv(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_drv(1'b0, 1'b1, 32'h7777_7777);
        #2;
        chk("rst_stray_d", 32'(bus.data_sram_data_ok), 32'd0);
        chk("rst_stray_i", 32'(bus.inst_sram_data_ok), 32'd0);
        tick();
        mem_drv(1'b0, 1'b0, 32'h0);
        tick();

        // Random traffic
        ipend = 1'b0;
        dpend = 1'b0;
        inst_req(1'b0, 32'h0);
        data_req(1'b0, 1'b0, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            if (!ipend && ($urandom_range(0, 99) < 40)) begin
                ipend = 1'b1;
                inst_req(1'b1, $urandom);
                bus.inst_sram_size = 2'($urandom_range(0, 3));
            end
            if (!dpend && ($urandom_range(0, 99) < 40)) begin
                dpend = 1'b1;
                data_req(1'b1, 1'($urandom_range(0, 1)), $urandom);
                bus.data_sram_wstrb = 4'($urandom);
            end
            mem_drv($urandom_range(0, 2) != 0, $urandom_range(0, 99) < 45, $urandom);
            bus.inst_cancel = ($urandom_range(0, 99) < 5);
            reset = ($urandom_range(0, 199) == 0);
            tick();
            if (e_iaok) begin
                ipend = 1'b0;
                bus.inst_sram_req = 1'b0;
            end
            if (e_daok) begin
                dpend = 1'b0;
                bus.data_sram_req = 1'b0;
            end
        end
        reset = 1'b0;
        bus.inst_cancel = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
